// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: ALU control decode + execute stage.
//   Decodes {alu_op, funct7, funct3} into a 4-bit control code and executes it
//   on op_a/op_b. Logic/arith ops finish in one cycle, shifts iterate
//   SHIFT_STEP bits per cycle. Result handed off over a valid/ready pair.
// Optional feature macro: ALU_MUL_EN (adds iterative shift-add multiply, code 1010).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only while idle)
//   alu_op/funct7/funct3 instruction decode fields
//   op_a/op_b           operands (shift amount = op_b[$clog2(XLEN)-1:0])
//   out_valid/out_ready result handshake
//   result/zero/illegal/alu_ctl  registered result, zero flag, decode error, code
`timescale 1ns/1ps
module alu_ctrl_exec #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      alu_ctl
);

    localparam int unsigned SW = $clog2(XLEN);
    // One extra bit so the counter can hold XLEN and compare against SHIFT_STEP.
    localparam int unsigned AW = SW + 1;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_XOR  = 4'b0011;
    localparam logic [3:0] CTL_SLL  = 4'b0100;
    localparam logic [3:0] CTL_SRL  = 4'b0101;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SRA  = 4'b0111;
    localparam logic [3:0] CTL_SLT  = 4'b1000;
    localparam logic [3:0] CTL_SLTU = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] CTL_MUL  = 4'b1010;
`endif
    localparam logic [3:0] CTL_ILL  = 4'b1111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t          state, state_d;
    logic [XLEN-1:0] acc, acc_d;
    logic [AW-1:0]   rem, rem_d;
    logic [XLEN-1:0] result_d;
    logic            zero_d, illegal_d, out_valid_d, in_ready_d;
    logic [3:0]      alu_ctl_d;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] aux, aux_d;
    logic [XLEN-1:0] prod, prod_d;
    logic [XLEN-1:0] prod_next;
`endif

    logic [3:0]      dec_ctl;
    logic [XLEN-1:0] single_res;
    logic            dec_shift;
    logic            dec_mul;
    logic            fire;
    logic [AW-1:0]   step_amt;
    logic [AW-1:0]   rem_next;
    logic [XLEN-1:0] shifted;

    // funct3 row shared by R-type (funct7=0) and I-type.
    function automatic logic [3:0] base_dec(input logic [2:0] f3, input logic arith);
        logic [3:0] c;
        case (f3)
            3'b000:  c = CTL_ADD;
            3'b001:  c = CTL_SLL;
            3'b010:  c = CTL_SLT;
            3'b011:  c = CTL_SLTU;
            3'b100:  c = CTL_XOR;
            3'b101:  c = arith ? CTL_SRA : CTL_SRL;
            3'b110:  c = CTL_OR;
            default: c = CTL_AND;
        endcase
        return c;
    endfunction

    // Control decode.
    always_comb begin
        dec_ctl = CTL_ILL;
        case (alu_op)
            2'b00: dec_ctl = CTL_ADD;
            2'b01: dec_ctl = CTL_SUB;
            2'b10: begin
                case (funct7)
                    7'b0000000: dec_ctl = base_dec(funct3, 1'b0);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_ctl = CTL_SUB;
                        else if (funct3 == 3'b101) dec_ctl = CTL_SRA;
                        else                       dec_ctl = CTL_ILL;
                    end
`ifdef ALU_MUL_EN
                    7'b0000001: dec_ctl = (funct3 == 3'b000) ? CTL_MUL : CTL_ILL;
`endif
                    default:    dec_ctl = CTL_ILL;
                endcase
            end
            default: dec_ctl = base_dec(funct3, funct7[5]);
        endcase
    end

    assign dec_shift = (dec_ctl == CTL_SLL) || (dec_ctl == CTL_SRL) || (dec_ctl == CTL_SRA);
`ifdef ALU_MUL_EN
    assign dec_mul   = (dec_ctl == CTL_MUL);
`else
    assign dec_mul   = 1'b0;
`endif
    assign fire      = in_valid && in_ready;

    // Single-cycle execute; illegal (and anything unlisted) yields zero.
    always_comb begin
        single_res = '0;
        case (dec_ctl)
            CTL_ADD:  single_res = op_a + op_b;
            CTL_SUB:  single_res = op_a - op_b;
            CTL_AND:  single_res = op_a & op_b;
            CTL_OR:   single_res = op_a | op_b;
            CTL_XOR:  single_res = op_a ^ op_b;
            CTL_SLT:  single_res = XLEN'($signed(op_a) < $signed(op_b));
            CTL_SLTU: single_res = XLEN'(op_a < op_b);
            default:  single_res = '0;
        endcase
    end

    // One shift step of min(remaining, SHIFT_STEP) bits on the working value.
    always_comb begin
        step_amt = (rem < AW'(SHIFT_STEP)) ? rem : AW'(SHIFT_STEP);
        rem_next = rem - step_amt;
        case (alu_ctl)
            CTL_SLL: shifted = acc << step_amt;
            CTL_SRA: shifted = $signed(acc) >>> step_amt;
            default: shifted = acc >> step_amt;
        endcase
    end

`ifdef ALU_MUL_EN
    assign prod_next = aux[0] ? (prod + acc) : prod;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        rem_d       = rem;
        result_d    = result;
        zero_d      = zero;
        illegal_d   = illegal;
        alu_ctl_d   = alu_ctl;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;
`ifdef ALU_MUL_EN
        aux_d       = aux;
        prod_d      = prod;
`endif
        case (state)
            S_IDLE: begin
                if (fire) begin
                    alu_ctl_d  = dec_ctl;
                    illegal_d  = 1'b0;
                    in_ready_d = 1'b0;
                    if (dec_shift) begin
                        acc_d = op_a;
                        rem_d = AW'(op_b[SW-1:0]);
                        if (op_b[SW-1:0] == '0) begin
                            // Zero shift amount completes immediately.
                            result_d    = op_a;
                            zero_d      = (op_a == '0);
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else if (dec_mul) begin
`ifdef ALU_MUL_EN
                        acc_d   = op_a;
                        aux_d   = op_b;
                        prod_d  = '0;
                        rem_d   = AW'(XLEN);
                        state_d = S_MUL;
`endif
                    end else begin
                        result_d    = single_res;
                        zero_d      = (single_res == '0);
                        illegal_d   = (dec_ctl == CTL_ILL);
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    result_d    = shifted;
                    zero_d      = (shifted == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`ifdef ALU_MUL_EN
            // Shift-add: multiplicand moves left, multiplier right, one bit per cycle.
            S_MUL: begin
                prod_d = prod_next;
                acc_d  = acc << 1;
                aux_d  = aux >> 1;
                rem_d  = rem - AW'(1);
                if (rem == AW'(1)) begin
                    result_d    = prod_next;
                    zero_d      = (prod_next == '0);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            rem       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            alu_ctl   <= 4'b0000;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ALU_MUL_EN
            aux       <= '0;
            prod      <= '0;
`endif
        end else begin
            acc       <= acc_d;
            rem       <= rem_d;
            result    <= result_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
            alu_ctl   <= alu_ctl_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
`ifdef ALU_MUL_EN
            aux       <= aux_d;
            prod      <= prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed self-checking bench for alu_ctrl_exec (XLEN=64; SHIFT_STEP=1 and 4).
`timescale 1ns/1ps
module tb_alu_ctrl_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid4;
    logic        in_ready, in_ready4;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [63:0] result, result4;
    logic        zero, zero4;
    logic        illegal, illegal4;
    logic [3:0]  alu_ctl, alu_ctl4;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    alu_ctrl_exec #(.XLEN(64), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .illegal(illegal), .alu_ctl(alu_ctl)
    );

    alu_ctrl_exec #(.XLEN(64), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .zero(zero4),
        .illegal(illegal4), .alu_ctl(alu_ctl4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b);
        alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
    endtask

    // Accept one op on dut, return cycles from accept to out_valid (bounded).
    task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, output int l);
        set_in(op, f7, f3, a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input logic [3:0] exp_ctl,
                       input int exp_lat, input logic exp_ill);
        int l;
        issue(op, f7, f3, a, b, l);
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, 64'(zero), 64'(exp_res == 64'd0));
        chk({tag, "_ctl"}, 64'(alu_ctl), 64'(exp_ctl));
        chk({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
        release_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
        set_in(2'b00, 7'd0, 3'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_ctl", 64'(alu_ctl), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("ld_add",  2'b00, 7'h7f, 3'd7, 64'h10, 64'h8, 64'h18, 4'b0010, 1, 1'b0);
        run("br_eq",   2'b01, 7'd0, 3'd0, 64'h55, 64'h55, 64'h0, 4'b0110, 1, 1'b0);
        run("br_ne",   2'b01, 7'd0, 3'd0, 64'h55, 64'h54, 64'h1, 4'b0110, 1, 1'b0);
        run("r_sra4",  2'b10, 7'b0100000, 3'b101, 64'h8000_0000_0000_0000, 64'd4,
            64'hF800_0000_0000_0000, 4'b0111, 5, 1'b0);
        run("r_ill",   2'b10, 7'b0000010, 3'b000, 64'h1234, 64'h5678, 64'h0, 4'b1111, 1, 1'b1);
        run("r_subf3", 2'b10, 7'b0100000, 3'b001, 64'h1, 64'h1, 64'h0, 4'b1111, 1, 1'b1);
        run("r_slt",   2'b10, 7'd0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b1000, 1, 1'b0);
        run("r_sltu",  2'b10, 7'd0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1001, 1, 1'b0);
        run("r_and",   2'b10, 7'd0, 3'b111, 64'hFF00, 64'h0FF0, 64'h0F00, 4'b0000, 1, 1'b0);
        run("r_or",    2'b10, 7'd0, 3'b110, 64'hFF00, 64'h0FF0, 64'hFFF0, 4'b0001, 1, 1'b0);
        run("r_sub_wrap", 2'b10, 7'b0100000, 3'b000, 64'd0, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 4'b0110, 1, 1'b0);
        run("i_addi",  2'b11, 7'b0100000, 3'b000, 64'd5, 64'd3, 64'd8, 4'b0010, 1, 1'b0);
        run("i_srli",  2'b11, 7'b0000000, 3'b101, 64'hF0, 64'd4, 64'h0F, 4'b0101, 5, 1'b0);
        run("i_srai",  2'b11, 7'b0100000, 3'b101, 64'hFFFF_FFFF_FFFF_FF00, 64'd3,
            64'hFFFF_FFFF_FFFF_FFE0, 4'b0111, 4, 1'b0);
        run("sll0",    2'b10, 7'd0, 3'b001, 64'hABC, 64'h40, 64'hABC, 4'b0100, 1, 1'b0);
        run("sll3",    2'b10, 7'd0, 3'b001, 64'h1, 64'd3, 64'h8, 4'b0100, 4, 1'b0);
        run("mulf3",   2'b10, 7'b0000001, 3'b001, 64'd7, 64'd6, 64'h0, 4'b1111, 1, 1'b1);
`ifdef ALU_MUL_EN
        run("mul",     2'b10, 7'b0000001, 3'b000, 64'd7, 64'd6, 64'd42, 4'b1010, 65, 1'b0);
`else
        run("mul_off", 2'b10, 7'b0000001, 3'b000, 64'd7, 64'd6, 64'h0, 4'b1111, 1, 1'b1);
`endif

        // Backpressure: result held, new request ignored.
        issue(2'b10, 7'd0, 3'b100, 64'hF0, 64'h0F, lat);
        chk("hold_lat", 64'(lat), 64'd1);
        set_in(2'b00, 7'd0, 3'd0, 64'd1, 64'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result, 64'hFF);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        release_out("hold");
        @(posedge clk); #1;
        chk("hold_no_ghost", 64'(out_valid), 64'd0);

        // Reset in the middle of a 40-bit shift.
        set_in(2'b10, 7'd0, 3'b001, 64'd1, 64'd40);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_result", result, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run("post_rst_add", 2'b00, 7'd0, 3'd0, 64'd3, 64'd4, 64'd7, 4'b0010, 1, 1'b0);

        // SHIFT_STEP=4 instance.
        set_in(2'b10, 7'b0100000, 3'b101, 64'h8000_0000_0000_0000, 64'd4);
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s4_sra_lat", 64'(lat), 64'd2);
        chk("s4_sra_result", result4, 64'hF800_0000_0000_0000);
        chk("s4_sra_ctl", 64'(alu_ctl4), 64'b0111);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("s4_in_ready", 64'(in_ready4), 64'd1);

        set_in(2'b10, 7'd0, 3'b101, 64'h100, 64'd5);
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s4_srl5_lat", 64'(lat), 64'd3);
        chk("s4_srl5_result", result4, 64'h8);
        chk("s4_srl5_zero", 64'(zero4), 64'd0);
        chk("s4_srl5_illegal", 64'(illegal4), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
